// File: rtl/arm_cond_pkg.sv
// Shared definitions for ARM conditional execution: condition codes and NZCV flag ordering.
// The ALU imports this package too, so both sides agree on flag bit positions.
package arm_cond_pkg;

  typedef enum logic [3:0] {
    CondEq = 4'h0,
    CondNe = 4'h1,
    CondCs = 4'h2,
    CondCc = 4'h3,
    CondMi = 4'h4,
    CondPl = 4'h5,
    CondVs = 4'h6,
    CondVc = 4'h7,
    CondHi = 4'h8,
    CondLs = 4'h9,
    CondGe = 4'hA,
    CondLt = 4'hB,
    CondGt = 4'hC,
    CondLe = 4'hD,
    CondAl = 4'hE,
    CondNv = 4'hF
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARM condition evaluator: condition field against stored NZCV flags.
module cond_check
  import arm_cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    cond_ex_o = 1'b0;
    unique case (cond_e'(cond_i))
      CondEq:  cond_ex_o = z;
      CondNe:  cond_ex_o = ~z;
      CondCs:  cond_ex_o = c;
      CondCc:  cond_ex_o = ~c;
      CondMi:  cond_ex_o = n;
      CondPl:  cond_ex_o = ~n;
      CondVs:  cond_ex_o = v;
      CondVc:  cond_ex_o = ~v;
      CondHi:  cond_ex_o = c & ~z;
      CondLs:  cond_ex_o = ~c | z;
      CondGe:  cond_ex_o = (n == v);
      CondLt:  cond_ex_o = (n != v);
      CondGt:  cond_ex_o = ~z & (n == v);
      CondLe:  cond_ex_o = z | (n != v);
      CondAl:  cond_ex_o = 1'b1;
      CondNv:  cond_ex_o = 1'b0;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: NZCV flag register, condition gating of decoder strobes,
// and executed/squashed instruction counters.
module cond_unit
  import arm_cond_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  input  logic [3:0]       cond_i,
  input  logic [3:0]       alu_flags_i,
  input  logic [1:0]       flag_w_i,
  input  logic             pcs_i,
  input  logic             reg_w_i,
  input  logic             mem_w_i,
  input  logic             no_write_i,
  input  logic             cnt_clr_i,
  output logic             cond_ex_o,
  output logic             pc_src_o,
  output logic             reg_write_o,
  output logic             mem_write_o,
  output logic [3:0]       flags_o,
  output logic [CNT_W-1:0] exec_cnt_o,
  output logic [CNT_W-1:0] squash_cnt_o
);

  logic [3:0]       flags_d, flags_q;
  logic [CNT_W-1:0] exec_cnt_d, exec_cnt_q;
  logic [CNT_W-1:0] squash_cnt_d, squash_cnt_q;
  logic             cond_ex;
  logic             exec, squash;

  // Evaluated against the registered flags so an instruction never sees its own result.
  cond_check u_cond_check (
    .cond_i    (cond_i),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  assign exec   = valid_i & cond_ex;
  assign squash = valid_i & ~cond_ex;

  always_comb begin
    flags_d = flags_q;
    if (exec && flag_w_i[1]) begin
      flags_d[FLAG_N] = alu_flags_i[FLAG_N];
      flags_d[FLAG_Z] = alu_flags_i[FLAG_Z];
    end
    if (exec && flag_w_i[0]) begin
      flags_d[FLAG_C] = alu_flags_i[FLAG_C];
      flags_d[FLAG_V] = alu_flags_i[FLAG_V];
    end
  end

  always_comb begin
    exec_cnt_d   = exec_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (cnt_clr_i) begin
      exec_cnt_d   = '0;
      squash_cnt_d = '0;
    end else begin
      if (exec)   exec_cnt_d   = exec_cnt_q + CNT_W'(1);
      if (squash) squash_cnt_d = squash_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      flags_q      <= '0;
      exec_cnt_q   <= '0;
      squash_cnt_q <= '0;
    end else begin
      flags_q      <= flags_d;
      exec_cnt_q   <= exec_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign cond_ex_o    = cond_ex;
  assign pc_src_o     = exec & pcs_i;
  assign reg_write_o  = exec & reg_w_i & ~no_write_i;
  assign mem_write_o  = exec & mem_w_i;
  assign flags_o      = flags_q;
  assign exec_cnt_o   = exec_cnt_q;
  assign squash_cnt_o = squash_cnt_q;

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution stage that sits directly downstream of the ALU in the single-cycle ARM datapath. Registers the ALU's NZCV flags under per-instruction write control, evaluates the 4-bit ARM condition field against the stored flags, and gates the decoder's PC-source, register-write and memory-write strobes. Also keeps executed and squashed instruction counters for bring-up and debug.

## Interface
Parameters:
- CNT_W, 32, width of both instruction counters

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  synchronous, active-low reset
- valid_i  in  1  an instruction is present this cycle
- cond_i  in  4  instruction condition field, Instr[31:28]
- alu_flags_i  in  4  ALU flags {N,Z,C,V}, bit 3 = N … bit 0 = V
- flag_w_i  in  2  [1] writes N,Z; [0] writes C,V
- pcs_i  in  1  decoder PC-source request
- reg_w_i  in  1  decoder register-write request
- mem_w_i  in  1  decoder memory-write request
- no_write_i  in  1  compare-class instruction; suppress register write
- cnt_clr_i  in  1  synchronous clear of both counters
- cond_ex_o  out  1  condition passed for the current instruction
- pc_src_o  out  1  gated PC-source
- reg_write_o  out  1  gated register write
- mem_write_o  out  1  gated memory write
- flags_o  out  4  registered flags {N,Z,C,V}
- exec_cnt_o  out  CNT_W  count of valid instructions whose condition passed
- squash_cnt_o  out  CNT_W  count of valid instructions whose condition failed

## Operation
- Flags register flags_q[3:0] holds the result of the last flag-writing instruction. Conditions are always evaluated against flags_q, never against alu_flags_i. An instruction cannot see its own flags.
- cond_ex_o is combinational from cond_i and flags_q:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0
- Gated outputs are combinational:
  - pc_src_o = valid_i & pcs_i & cond_ex_o
  - reg_write_o = valid_i & reg_w_i & cond_ex_o & !no_write_i
  - mem_write_o = valid_i & mem_w_i & cond_ex_o
- Flag update at the clock edge when valid_i & cond_ex_o:
  - flag_w_i[1] loads N,Z from alu_flags_i[3:2].
  - flag_w_i[0] loads C,V from alu_flags_i[1:0].
  - The two halves are independent. Flag bits not written hold their value.
- Failed condition or valid_i=0: no flag write, all gated outputs 0.
- Counters:
  - exec_cnt increments on valid_i & cond_ex_o.
  - squash_cnt increments on valid_i & !cond_ex_o.
  - Both wrap modulo 2^CNT_W with no saturation or sticky bit.
  - cnt_clr_i has priority over increment: counter is 0 next cycle regardless of that cycle's instruction.
  - cnt_clr_i does not affect flags_q.
- flags_o = flags_q; exec_cnt_o and squash_cnt_o are direct register outputs.

## Timing
- Reset (rst_n_i=0 at edge): flags_q=0000, exec_cnt=0, squash_cnt=0.
- Combinational outputs during reset: they follow their equations with flags_q=0. With cond_i=EQ they read 0; with AL they pass the request through when valid_i=1. Reset has priority over every update in the same cycle.
- Reset mid-operation discards any pending flag write.
- Latency:
  - Gated strobes and cond_ex_o: 0 cycles, combinational.
  - Flag update: visible on flags_o and to the next instruction's condition one cycle after the writing instruction.
  - Counters: visible one cycle after the counted instruction.
- Back-to-back: CMP in cycle n followed by a conditional instruction in cycle n+1 uses the CMP result. No bubble is required.
- Counter wrap: all-ones + increment gives 0 at the next edge.

## Structure
- Package arm_cond_pkg:
  - cond_e enum for the 16 codes (EQ..NV).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - The ALU uses the same package for flag ordering.
- Sub-module cond_check: purely combinational (cond_i, flags) → cond_ex, case over cond_e. cond_unit instantiates it plus the flag register and the two counters.

## Test plan
- Reset, then CMP-style write. Apply rst_n_i=0, then valid_i=1, cond=AL, flag_w=11, alu_flags=0100 → next cycle flags_o=0100, exec_cnt_o=1.
- EQ/NE after that. With flags_q=0100: cond=EQ, reg_w=1 → reg_write_o=1. cond=NE → reg_write_o=0, squash_cnt increments, flags unchanged even with flag_w=11.
- Partial write. With flags_q=1111, flag_w=01, alu_flags=0000 → flags_o=1100. Then flag_w=10, alu_flags=0000 → flags_o=0000.
- Signed conditions:
  - flags 1001 (N=V=1): GE=1, LT=0, GT=1, LE=0.
  - flags 0010: HI=1, LS=0.
  - NV always 0 with pcs_i=mem_w_i=1.
- no_write_i and valid_i gating:
  - cond=AL, reg_w=1, no_write=1 → reg_write_o=0, flags still written.
  - valid_i=0 → all gated outputs 0, counters and flags hold.
- Counters:
  - Preload to all-ones (CNT_W=4 build), one passing instruction → exec_cnt_o=0.
  - cnt_clr_i asserted with a passing instruction in the same cycle → exec_cnt_o=0 next cycle.
  - Reset asserted alongside flag_w=11 → flags_o=0000.
